// File: rtl/player_missile_ctrl_pkg.sv
// Shared defaults and slot-state encoding for the player missile controller.
package player_missile_ctrl_pkg;

  localparam int unsigned PM_NUM_MISSILES = 4;
  localparam int unsigned PM_MISSILE_STEP = 4;
  localparam int unsigned PM_COOLDOWN     = 8;
  localparam int unsigned PM_SPAWN_OFFSET = 6;
  localparam int unsigned COORD_W         = 10;
  localparam int unsigned SHOTS_W         = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    FLYING = 1'b1
  } slot_state_e;

endpackage

// File: rtl/player_missile_ctrl_missile_slot.sv
// One missile slot: spawns on request, climbs MISSILE_STEP per frame, frees on hit or top exit.
module missile_slot
  import player_missile_ctrl_pkg::*;
#(
  parameter int unsigned MISSILE_STEP = PM_MISSILE_STEP
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               spawn,
  input  logic               hit,
  input  logic [COORD_W-1:0] spawn_x,
  input  logic [COORD_W-1:0] spawn_y,
  output logic [COORD_W-1:0] missile_x,
  output logic [COORD_W-1:0] missile_y,
  output logic               active
);

  localparam logic [COORD_W-1:0] STEP = COORD_W'(MISSILE_STEP);

  slot_state_e        state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Hit beats move; a slot about to underflow leaves through the top edge instead.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (spawn) begin
          state_d = FLYING;
          x_d     = spawn_x;
          y_d     = spawn_y;
        end
      end
      FLYING: begin
        if (hit || (y_q < STEP)) begin
          state_d = IDLE;
        end else begin
          y_d = y_q - STEP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign missile_x = x_q;
  assign missile_y = y_q;
  assign active    = (state_q == FLYING);

endmodule

// File: rtl/player_missile_ctrl.sv
// Player missile controller: fire edge detect, cooldown, lowest-free-slot arbitration, shot counter.
module player_missile_ctrl
  import player_missile_ctrl_pkg::*;
#(
  parameter int unsigned NUM_MISSILES = PM_NUM_MISSILES,
  parameter int unsigned MISSILE_STEP = PM_MISSILE_STEP,
  parameter int unsigned COOLDOWN     = PM_COOLDOWN,
  parameter int unsigned SPAWN_OFFSET = PM_SPAWN_OFFSET
) (
  input  logic                              frame_clk,
  input  logic                              Reset,
  input  logic                              player_shoot,
  input  logic [COORD_W-1:0]                PlayerX,
  input  logic [COORD_W-1:0]                PlayerY,
  input  logic [NUM_MISSILES-1:0]           hit,
  output logic [NUM_MISSILES*COORD_W-1:0]   MissileX,
  output logic [NUM_MISSILES*COORD_W-1:0]   MissileY,
  output logic [NUM_MISSILES-1:0]           missile_active,
  output logic [SHOTS_W-1:0]                shots_fired
);

  localparam int unsigned       CD_W    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CD_W-1:0]   CD_LOAD = (COOLDOWN > 0) ? CD_W'(COOLDOWN - 1) : '0;

  logic                    shoot_prev_q, shoot_prev_d;
  logic                    armed_q, armed_d;
  logic [CD_W-1:0]         cooldown_q, cooldown_d;
  logic [SHOTS_W-1:0]      shots_fired_q, shots_fired_d;
  logic                    shoot_rise;
  logic                    accept;
  logic                    found;
  logic [NUM_MISSILES-1:0] spawn;
  logic [COORD_W-1:0]      spawn_y;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      shoot_prev_q  <= 1'b0;
      armed_q       <= 1'b0;
      cooldown_q    <= '0;
      shots_fired_q <= '0;
    end else begin
      shoot_prev_q  <= shoot_prev_d;
      armed_q       <= armed_d;
      cooldown_q    <= cooldown_d;
      shots_fired_q <= shots_fired_d;
    end
  end

  // armed_q records a released key since reset, so a key held through reset cannot fire.
  always_comb begin
    shoot_prev_d  = player_shoot;
    armed_d       = armed_q | ~player_shoot;
    shoot_rise    = player_shoot & ~shoot_prev_q & armed_q;
    accept        = shoot_rise && (cooldown_q == '0) && !(&missile_active);
    cooldown_d    = (cooldown_q != '0) ? cooldown_q - CD_W'(1) : '0;
    shots_fired_d = shots_fired_q;
    spawn         = '0;
    found         = 1'b0;
    if (accept) begin
      cooldown_d    = CD_LOAD;
      shots_fired_d = shots_fired_q + SHOTS_W'(1);
      for (int i = 0; i < int'(NUM_MISSILES); i++) begin
        if (!found && !missile_active[i]) begin
          spawn[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  assign spawn_y     = PlayerY - COORD_W'(SPAWN_OFFSET);
  assign shots_fired = shots_fired_q;

  for (genvar g = 0; g < int'(NUM_MISSILES); g++) begin : g_slot
    missile_slot #(
      .MISSILE_STEP(MISSILE_STEP)
    ) u_slot (
      .frame_clk(frame_clk),
      .Reset    (Reset),
      .spawn    (spawn[g]),
      .hit      (hit[g]),
      .spawn_x  (PlayerX),
      .spawn_y  (spawn_y),
      .missile_x(MissileX[g*COORD_W +: COORD_W]),
      .missile_y(MissileY[g*COORD_W +: COORD_W]),
      .active   (missile_active[g])
    );
  end

endmodule

// File: tb/tb_player_missile_ctrl.sv
// Directed bench for player_missile_ctrl with hand-computed expectations.
module tb_player_missile_ctrl;

  logic        frame_clk;
  logic        Reset;
  logic        player_shoot;
  logic [9:0]  PlayerX, PlayerY;
  logic [3:0]  hit;
  logic [39:0] MissileX, MissileY;
  logic [3:0]  missile_active;
  logic [7:0]  shots_fired;

  int n_checks = 0;
  int n_fail   = 0;

  player_missile_ctrl dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .player_shoot  (player_shoot),
    .PlayerX       (PlayerX),
    .PlayerY       (PlayerY),
    .hit           (hit),
    .MissileX      (MissileX),
    .MissileY      (MissileY),
    .missile_active(missile_active),
    .shots_fired   (shots_fired)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  function automatic logic [9:0] mx(int i);
    return MissileX[i*10 +: 10];
  endfunction

  function automatic logic [9:0] my(int i);
    return MissileY[i*10 +: 10];
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n frames, landing 1 time unit after the last rising edge.
  task automatic frame(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    Reset        = 1'b1;
    player_shoot = 1'b0;
    hit          = 4'b0000;
    frame(2);
    Reset = 1'b0;
    frame(1);
  endtask

  initial begin
    Reset        = 1'b1;
    player_shoot = 1'b0;
    PlayerX      = 10'd320;
    PlayerY      = 10'd240;
    hit          = 4'b0000;
    #3;
    chk("rst_active", missile_active, 4'b0000);
    chk("rst_shots", shots_fired, 8'd0);
    chk("rst_x", MissileX, 40'd0);
    chk("rst_y", MissileY, 40'd0);
    frame(2);
    Reset = 1'b0;
    frame(1);
    chk("idle_active", missile_active, 4'b0000);

    // Single pulse spawns slot0 at (320,234) then climbs.
    player_shoot = 1'b1;
    frame(1);
    chk("spawn_active", missile_active, 4'b0001);
    chk("spawn_x0", mx(0), 10'd320);
    chk("spawn_y0", my(0), 10'd234);
    chk("spawn_shots", shots_fired, 8'd1);
    player_shoot = 1'b0;
    frame(1);
    chk("move_y0", my(0), 10'd230);
    chk("move_x0", mx(0), 10'd320);

    // Holding the key fires once.
    do_reset();
    player_shoot = 1'b1;
    frame(20);
    chk("hold_shots", shots_fired, 8'd1);
    chk("hold_active", missile_active, 4'b0001);
    chk("hold_y0", my(0), 10'd158);
    player_shoot = 1'b0;

    // Cooldown drops a pulse 2 frames later; pulse 8 frames later goes to slot1.
    do_reset();
    player_shoot = 1'b1; frame(1);
    player_shoot = 1'b0; frame(1);
    player_shoot = 1'b1; frame(1);
    chk("cd_drop_shots", shots_fired, 8'd1);
    chk("cd_drop_active", missile_active, 4'b0001);
    player_shoot = 1'b0; frame(5);
    player_shoot = 1'b1; frame(1);
    chk("cd_ok_active", missile_active, 4'b0011);
    chk("cd_ok_shots", shots_fired, 8'd2);
    chk("cd_ok_y1", my(1), 10'd234);
    chk("cd_ok_y0", my(0), 10'd202);
    player_shoot = 1'b0;

    // Fill all slots, fifth shot dropped, hit frees slot2 for the next shot.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      player_shoot = 1'b1; frame(1);
      player_shoot = 1'b0; frame(7);
    end
    chk("full_active", missile_active, 4'b1111);
    chk("full_shots", shots_fired, 8'd4);
    player_shoot = 1'b1; frame(1);
    chk("full_drop_shots", shots_fired, 8'd4);
    player_shoot = 1'b0;
    hit = 4'b0100; frame(1);
    chk("hit_active", missile_active, 4'b1011);
    hit     = 4'b0000;
    PlayerX = 10'd100;
    player_shoot = 1'b1; frame(1);
    chk("reuse_active", missile_active, 4'b1111);
    chk("reuse_shots", shots_fired, 8'd5);
    chk("reuse_x2", mx(2), 10'd100);
    chk("reuse_y2", my(2), 10'd234);
    chk("reuse_y0", my(0), 10'd98);
    player_shoot = 1'b0;
    PlayerX = 10'd320;

    // Near the top: 10 -> 6 -> 2 -> IDLE holding Y=2.
    do_reset();
    PlayerY = 10'd16;
    player_shoot = 1'b1; frame(1);
    chk("top_y_a", my(0), 10'd10);
    player_shoot = 1'b0; frame(1);
    chk("top_y_b", my(0), 10'd6);
    frame(1);
    chk("top_y_c", my(0), 10'd2);
    chk("top_active_c", missile_active, 4'b0001);
    frame(1);
    chk("top_exit_active", missile_active, 4'b0000);
    chk("top_hold_y", my(0), 10'd2);
    PlayerY = 10'd240;

    // Reset mid-flight with shoot held: no fire until released and re-pressed.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      player_shoot = 1'b1; frame(1);
      player_shoot = 1'b0; frame(7);
    end
    chk("pre_rst_active", missile_active, 4'b0111);
    player_shoot = 1'b1;
    Reset        = 1'b1;
    #1;
    chk("mid_rst_active", missile_active, 4'b0000);
    chk("mid_rst_x", MissileX, 40'd0);
    chk("mid_rst_y", MissileY, 40'd0);
    chk("mid_rst_shots", shots_fired, 8'd0);
    frame(2);
    Reset = 1'b0;
    frame(5);
    chk("held_active", missile_active, 4'b0000);
    chk("held_shots", shots_fired, 8'd0);
    player_shoot = 1'b0; frame(1);
    player_shoot = 1'b1; frame(1);
    chk("repress_active", missile_active, 4'b0001);
    chk("repress_shots", shots_fired, 8'd1);
    player_shoot = 1'b0;
    frame(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
